mem_access: RTL
===============

# mem_access

Pipelined memory-access stage for the RISC-V core, sitting between the execute stage and write-back. It forwards ALU results unchanged and executes loads and stores against the data-memory bus with a request/acknowledge handshake, stalling the upstream stage until the access completes. It adds byte/half/word/double sizing with sign or zero extension, byte-enable generation, misalignment detection and a bus timeout. Outputs are registered, so the block also serves as the MEM/WB pipeline register.

## Interface
- DATA_W, 32: register and bus data width; legal values are 32 and 64.
- ADDR_W, 32: data-memory address width.
- REG_ADDR_W, 5: register-file address width.
- TIMEOUT, 16: number of cycles `dm_req` may stay high without `dm_ack` before a bus fault is raised; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low; rst==0 at a rising edge resets the block.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  block accepts the instruction; high only in IDLE.
- mem_en_i  in  1  instruction is a load or store.
- mem_we_i  in  1  1 = store, 0 = load; ignored when mem_en_i==0.
- mem_op_i  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- mem_addr_i  in  ADDR_W  effective byte address.
- store_data_i  in  DATA_W  store data, right-aligned.
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  destination write enable.
- wdata_i  in  DATA_W  ALU result.
- dm_req  out  1  bus request, registered.
- dm_we  out  1  bus write.
- dm_addr  out  ADDR_W  address aligned to DATA_W/8 bytes.
- dm_be  out  DATA_W/8  byte enables.
- dm_wdata  out  DATA_W  store data shifted into byte lanes.
- dm_ack  in  1  access complete; for loads, dm_rdata is valid in this cycle.
- dm_rdata  in  DATA_W  read data.
- out_valid  out  1  one-cycle pulse; write-back consumes the outputs below.
- wd_o  out  REG_ADDR_W  destination register.
- wreg_o  out  1  register write enable.
- wdata_o  out  DATA_W  write-back data.
- fault_o  out  1  qualifies fault_cause_o; valid when out_valid is high.
- fault_cause_o  out  2  01 misaligned, 10 bus timeout, 11 illegal size.

## Operation
- States: IDLE and BUSY. in_ready = (state==IDLE).
- IDLE with in_valid and mem_en_i==0: the next edge registers wd_i, wreg_i and wdata_i to the outputs and pulses out_valid. The state stays IDLE.
- IDLE with in_valid and mem_en_i==1, legal and aligned: the next edge latches the operation, asserts dm_req, dm_we, dm_addr, dm_be and dm_wdata, and moves to BUSY. The timeout counter clears.
- Size rules:
  - Size D, or WU, with DATA_W==32 is illegal: cause 11.
  - Size H needs addr[0]==0; W needs addr[1:0]==0; D needs addr[2:0]==0. Any violation is misaligned: cause 01.
  - Illegal-size and misaligned instructions never touch the bus. Out_valid pulses on the next edge with wreg_o=0 and fault_o=1; illegal size takes priority over misalignment.
- Byte enables: a run of set bits, 1, 2, 4 or 8 bits wide, starting at lane addr mod (DATA_W/8). dm_wdata is store_data_i shifted left by 8×lane bits.
- BUSY:
  - dm_req and its bus fields are held stable until the ack edge.
  - The counter increments each cycle that dm_ack is low.
- BUSY with dm_ack at an edge: the next state is IDLE and dm_req drops. Out_valid pulses with fault_o=0.
  - Load: wdata_o is the selected lanes of dm_rdata, sign-extended for B/H/W and zero-extended for BU/HU/WU, to DATA_W. wreg_o is wreg_i.
  - Store: wreg_o=0.
- BUSY with counter==TIMEOUT-1 and no dm_ack: the next state is IDLE and dm_req drops. Out_valid pulses with fault_o=1, cause 10, wreg_o=0.
- dm_ack while IDLE is ignored.
- Values in an x0 destination pass through unchanged; write-back suppresses them.

## Timing
- Reset values: state IDLE, dm_req 0, dm_we 0, dm_addr 0, dm_be 0, dm_wdata 0, out_valid 0, wd_o 0, wreg_o 0, wdata_o 0, fault_o 0, fault_cause_o 00, counter 0.
- Non-memory and faulting instructions take 1 cycle: accepted at edge N, out_valid high after edge N.
- Memory access: accepted at edge N, dm_req high after N. An ack sampled at edge N+k (k≥1) gives out_valid after N+k; minimum latency is 1 edge after the request.
- in_ready rises in the same cycle as out_valid, so back-to-back accept is possible. No bubble is needed after a memory access.
- A reset edge during BUSY drops dm_req and produces no out_valid. A late dm_ack after reset is ignored.
- Outputs other than out_valid hold their last values between pulses.

## Test plan
- ALU pass-through: in_valid, mem_en_i=0, wd_i=5, wdata_i=0x1234 → next cycle out_valid=1, wd_o=5, wreg_o=1, wdata_o=0x1234.
- LB at 0x1003 with dm_ack 3 cycles after dm_req, dm_rdata=0x80FF_FFFF → dm_addr=0x1000, dm_be=1000. Out_valid comes on the ack edge with wdata_o=0xFFFF_FF80. in_ready is low throughout.
- SH at 0x2002, store_data_i=0xABCD_1234, immediate ack → dm_we=1, dm_be=1100, dm_wdata=0x1234_0000. Out_valid comes with wreg_o=0.
- LW at 0x3001 → no dm_req; next cycle fault_o=1, cause 01, wreg_o=0. With DATA_W=32, LD → cause 11.
- TIMEOUT=4, LW with no ack → dm_req high for exactly 4 cycles. Out_valid follows with cause 10. A later stray dm_ack is ignored.
- rst=0 for one edge while BUSY → dm_req is 0 after that edge, no out_valid, in_ready=1.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage (master) and data memory (slave).
interface mem_access_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W/8-1:0]   dm_be;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  dm_ack;
  logic [DATA_W-1:0]     dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: ALU pass-through, sized loads/stores over a
// req/ack bus with misalignment, illegal-size and timeout faults. All outputs
// are registered, so this block doubles as the MEM/WB pipeline register.
module mem_access #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mem_en_i,
  input  logic                  mem_we_i,
  input  logic [2:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  mem_access_if.master          bus,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  fault_o,
  output logic [1:0]            fault_cause_o
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Registered state and outputs
  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_dm_req, r_dm_we;
  logic [ADDR_W-1:0]     r_dm_addr;
  logic [BE_W-1:0]       r_dm_be;
  logic [DATA_W-1:0]     r_dm_wdata;
  logic                  r_out_valid, r_wreg_o, r_fault_o;
  logic [REG_ADDR_W-1:0] r_wd_o;
  logic [DATA_W-1:0]     r_wdata_o;
  logic [1:0]            r_fault_cause_o;
  logic [CNT_W-1:0]      r_cnt;
  // Operation latched at accept for use on the ack edge
  logic [2:0]            r_op;
  logic [LANE_W-1:0]     r_lane;
  logic                  r_we, r_wreg;
  logic [REG_ADDR_W-1:0] r_wd;

  // Next-state values
  state_t                w_state;
  logic                  w_in_ready;
  logic                  w_dm_req, w_dm_we;
  logic [ADDR_W-1:0]     w_dm_addr;
  logic [BE_W-1:0]       w_dm_be;
  logic [DATA_W-1:0]     w_dm_wdata;
  logic                  w_out_valid, w_wreg_o, w_fault_o;
  logic [REG_ADDR_W-1:0] w_wd_o;
  logic [DATA_W-1:0]     w_wdata_o;
  logic [1:0]            w_fault_cause_o;
  logic [CNT_W-1:0]      w_cnt;
  logic [2:0]            w_op;
  logic [LANE_W-1:0]     w_lane_q;
  logic                  w_we, w_wreg;
  logic [REG_ADDR_W-1:0] w_wd;

  // Decode results
  logic [LANE_W-1:0]     w_lane;
  logic [BE_W-1:0]       w_be_base;
  logic                  w_illegal, w_misaligned;
  logic [DATA_W-1:0]     w_st_data;
  logic [DATA_W-1:0]     w_rd_sh;
  logic [DATA_W-1:0]     w_ld_data;

  // Request decode: lane, byte enables, legality and alignment
  always_comb begin
    w_lane       = mem_addr_i[LANE_W-1:0];
    w_be_base    = BE_W'(1);
    w_misaligned = 1'b0;
    case (mem_op_i[1:0])
      2'b00: w_be_base = BE_W'(1);
      2'b01: begin
        w_be_base    = BE_W'(3);
        w_misaligned = mem_addr_i[0];
      end
      2'b10: begin
        w_be_base    = BE_W'(15);
        w_misaligned = (mem_addr_i[1:0] != 2'b00);
      end
      default: begin
        w_be_base    = {BE_W{1'b1}};
        w_misaligned = (mem_addr_i[2:0] != 3'b000);
      end
    endcase
    w_illegal = (mem_op_i == 3'b111) ||
                ((DATA_W == 32) && ((mem_op_i[1:0] == 2'b11) || (mem_op_i == 3'b110)));
    w_st_data = store_data_i << {w_lane, 3'b000};
  end

  // Load data: pick the addressed lanes and sign/zero extend
  always_comb begin
    w_rd_sh = bus.dm_rdata >> {r_lane, 3'b000};
    case (r_op)
      3'b000:  w_ld_data = DATA_W'($signed(w_rd_sh[7:0]));
      3'b001:  w_ld_data = DATA_W'($signed(w_rd_sh[15:0]));
      3'b010:  w_ld_data = DATA_W'($signed(w_rd_sh[31:0]));
      3'b100:  w_ld_data = DATA_W'(w_rd_sh[7:0]);
      3'b101:  w_ld_data = DATA_W'(w_rd_sh[15:0]);
      3'b110:  w_ld_data = DATA_W'(w_rd_sh[31:0]);
      default: w_ld_data = w_rd_sh;
    endcase
  end

  // FSM next-state and output logic
  always_comb begin
    w_state         = r_state;
    w_dm_req        = r_dm_req;
    w_dm_we         = r_dm_we;
    w_dm_addr       = r_dm_addr;
    w_dm_be         = r_dm_be;
    w_dm_wdata      = r_dm_wdata;
    w_out_valid     = 1'b0;
    w_wd_o          = r_wd_o;
    w_wreg_o        = r_wreg_o;
    w_wdata_o       = r_wdata_o;
    w_fault_o       = r_fault_o;
    w_fault_cause_o = r_fault_cause_o;
    w_cnt           = r_cnt;
    w_op            = r_op;
    w_lane_q        = r_lane;
    w_we            = r_we;
    w_wreg          = r_wreg;
    w_wd            = r_wd;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (!mem_en_i) begin
            w_out_valid     = 1'b1;
            w_wd_o          = wd_i;
            w_wreg_o        = wreg_i;
            w_wdata_o       = wdata_i;
            w_fault_o       = 1'b0;
            w_fault_cause_o = CAUSE_NONE;
          end else if (w_illegal || w_misaligned) begin
            w_out_valid     = 1'b1;
            w_wd_o          = wd_i;
            w_wreg_o        = 1'b0;
            w_fault_o       = 1'b1;
            w_fault_cause_o = w_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
          end else begin
            w_state    = S_BUSY;
            w_dm_req   = 1'b1;
            w_dm_we    = mem_we_i;
            w_dm_addr  = {mem_addr_i[ADDR_W-1:LANE_W], LANE_W'(0)};
            w_dm_be    = w_be_base << w_lane;
            w_dm_wdata = w_st_data;
            w_cnt      = '0;
            w_op       = mem_op_i;
            w_lane_q   = w_lane;
            w_we       = mem_we_i;
            w_wreg     = wreg_i;
            w_wd       = wd_i;
          end
        end
      end
      S_BUSY: begin
        if (bus.dm_ack) begin
          w_state         = S_IDLE;
          w_dm_req        = 1'b0;
          w_out_valid     = 1'b1;
          w_wd_o          = r_wd;
          w_wreg_o        = r_we ? 1'b0 : r_wreg;
          w_wdata_o       = r_we ? r_wdata_o : w_ld_data;
          w_fault_o       = 1'b0;
          w_fault_cause_o = CAUSE_NONE;
        end else if (r_cnt == CNT_LAST) begin
          w_state         = S_IDLE;
          w_dm_req        = 1'b0;
          w_out_valid     = 1'b1;
          w_wd_o          = r_wd;
          w_wreg_o        = 1'b0;
          w_fault_o       = 1'b1;
          w_fault_cause_o = CAUSE_TIMEOUT;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_in_ready = (w_state == S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_in_ready      <= 1'b1;
      r_dm_req        <= 1'b0;
      r_dm_we         <= 1'b0;
      r_dm_addr       <= '0;
      r_dm_be         <= '0;
      r_dm_wdata      <= '0;
      r_out_valid     <= 1'b0;
      r_wd_o          <= '0;
      r_wreg_o        <= 1'b0;
      r_wdata_o       <= '0;
      r_fault_o       <= 1'b0;
      r_fault_cause_o <= CAUSE_NONE;
      r_cnt           <= '0;
      r_op            <= '0;
      r_lane          <= '0;
      r_we            <= 1'b0;
      r_wreg          <= 1'b0;
      r_wd            <= '0;
    end else begin
      r_state         <= w_state;
      r_in_ready      <= w_in_ready;
      r_dm_req        <= w_dm_req;
      r_dm_we         <= w_dm_we;
      r_dm_addr       <= w_dm_addr;
      r_dm_be         <= w_dm_be;
      r_dm_wdata      <= w_dm_wdata;
      r_out_valid     <= w_out_valid;
      r_wd_o          <= w_wd_o;
      r_wreg_o        <= w_wreg_o;
      r_wdata_o       <= w_wdata_o;
      r_fault_o       <= w_fault_o;
      r_fault_cause_o <= w_fault_cause_o;
      r_cnt           <= w_cnt;
      r_op            <= w_op;
      r_lane          <= w_lane_q;
      r_we            <= w_we;
      r_wreg          <= w_wreg;
      r_wd            <= w_wd;
    end
  end

  assign in_ready      = r_in_ready;
  assign bus.dm_req    = r_dm_req;
  assign bus.dm_we     = r_dm_we;
  assign bus.dm_addr   = r_dm_addr;
  assign bus.dm_be     = r_dm_be;
  assign bus.dm_wdata  = r_dm_wdata;
  assign out_valid     = r_out_valid;
  assign wd_o          = r_wd_o;
  assign wreg_o        = r_wreg_o;
  assign wdata_o       = r_wdata_o;
  assign fault_o       = r_fault_o;
  assign fault_cause_o = r_fault_cause_o;

endmodule
